// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// spi_slave : SPI mode-0 byte slave, oversampled in the clk domain,
//             with a single-entry transmit holding register.
// Revision  : 1.0
// ----------------------------------------------------------------------------
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_underrun
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       cs_meta, cs_sync, cs_prev;
  logic       mosi_meta, mosi_sync, mosi_prev;
  logic [1:0] settle;
  logic [2:0] cnt;
  logic       rose;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] hold_data;
  logic       hold_full;

  logic       settled, sclk_rise, sclk_fall, cs_fall;
  logic       frame_start, frame_end, in_frame, byte_start;
  logic [7:0] rx_next;

  assign settled     = settle[1];
  assign sclk_rise   = sclk_sync & ~sclk_prev;
  assign sclk_fall   = ~sclk_sync & sclk_prev;
  assign cs_fall     = ~cs_sync & cs_prev;
  assign frame_start = (state == ST_IDLE) && cs_fall;
  assign frame_end   = (state == ST_ACTIVE) && cs_sync;
  assign in_frame    = (state == ST_ACTIVE) && !cs_sync;
  assign byte_start  = frame_start || (in_frame && sclk_rise && cnt == 3'd7);
  assign rx_next     = {rx_shift, mosi_sync};
  assign tx_ready    = !hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta <= 1'b0; sclk_sync <= 1'b0; sclk_prev <= 1'b0;
      cs_meta   <= 1'b1; cs_sync   <= 1'b1; cs_prev   <= 1'b1;
      mosi_meta <= 1'b0; mosi_sync <= 1'b0; mosi_prev <= 1'b0;
      settle    <= 2'd0;
      state     <= ST_WAIT;
    end else begin
      sclk_meta <= sclk; sclk_sync <= sclk_meta; sclk_prev <= sclk_sync;
      cs_meta   <= cs_n; cs_sync   <= cs_meta;   cs_prev   <= cs_sync;
      mosi_meta <= mosi; mosi_sync <= mosi_meta; mosi_prev <= mosi_sync;
      if (!settled) settle <= settle + 2'd1;
      state     <= state_next;
    end
  end

  // ST_WAIT holds off until synchronizers carry real pin values and cs_n is
  // seen high, so a reset inside a frame cannot fake a cs_n falling edge.
  always_comb begin
    state_next = state;
    miso_oe    = 1'b0;
    miso       = 1'b0;
    case (state)
      ST_WAIT:   if (settled && cs_sync) state_next = ST_IDLE;
      ST_IDLE:   if (cs_fall) state_next = ST_ACTIVE;
      ST_ACTIVE: begin
        miso_oe = 1'b1;
        miso    = tx_shift[7];
        if (cs_sync) state_next = ST_IDLE;
      end
      default:   state_next = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 3'd0;
      rose        <= 1'b0;
      rx_shift    <= 7'd0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_shift    <= 8'h00;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (frame_start || frame_end) begin
        cnt  <= 3'd0;
        rose <= 1'b0;
      end else if (in_frame) begin
        if (sclk_rise) begin
          rx_shift <= rx_next[6:0];
          cnt      <= cnt + 3'd1;
          rose     <= (cnt != 3'd7);
          if (cnt == 3'd7) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
          end
        end else if (sclk_fall && rose) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
      // A same-cycle write cannot collide: writes need the register empty.
      if (byte_start) begin
        tx_shift    <= hold_full ? hold_data : IDLE_BYTE;
        tx_underrun <= !hold_full;
        if (hold_full) hold_full <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

Synthesizable SPI slave (mode 0, MSB first, 8-bit) that sits directly downstream of the bench `spi_master` model and receives its `cycle` transfers. It oversamples `sclk`/`cs_n`/`mosi` in the system clock domain, delivers each received byte with a one-cycle strobe, and returns a byte on `miso` using a single-entry transmit holding register with a valid/ready handshake.

## Interface
- `IDLE_BYTE`, 8'h00, byte shifted out when no transmit byte is pending at a byte start
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `sclk`  in  1  SPI serial clock (asynchronous to `clk`)
- `cs_n`  in  1  SPI chip select, active low (asynchronous)
- `mosi`  in  1  SPI master-out data (asynchronous)
- `miso`  out  1  SPI master-in data
- `miso_oe`  out  1  output enable for `miso` pad; high while frame active
- `rx_data`  out  8  last received byte; held until the next byte completes
- `rx_valid`  out  1  one-cycle strobe, `rx_data` new
- `tx_data`  in  8  byte to return on the next byte start
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  holding register empty; transfer on `tx_valid & tx_ready`
- `tx_underrun`  out  1  one-cycle strobe: byte start with empty holding register

## Operation
- Input sync: `sclk`, `cs_n`, `mosi` each pass through 2 flops, then a third "previous" flop for edge detect. Edges are taken only from synchronized values.
- Frame: `cs_n` synced falling edge starts a frame. Synced high ends it. A frame carries any number of bytes.
- Bit counter `cnt` (3 bits) counts synced `sclk` rising edges within the frame. It resets to 0 at frame start and frame end.
- Rising edge: shift synced `mosi` into `rx_shift` LSB-first position (MSB received first).
  - If `cnt`==7, the next cycle sets `rx_data` to the completed byte and pulses `rx_valid`.
  - `cnt` then wraps to 0 and a byte start occurs.
- Byte start (frame start, or wrap from `cnt`==7):
  - `tx_shift` loads the holding register if it is full; the holding register is then cleared and `tx_ready` goes to 1.
  - Otherwise `tx_shift` loads `IDLE_BYTE` and `tx_underrun` pulses.
  - `miso` presents bit 7 immediately.
- Falling edge: advances `miso` to the next bit, but only if at least one rising edge has occurred in the current byte. This rejects the spurious falling edge when `sclk` idles high across a frame boundary.
- Frame end mid-byte (`cnt`≠0): discard the partial byte; no `rx_valid`. A `tx_shift` byte already loaded is dropped, not retried.
- Holding register:
  - Written when `tx_valid & tx_ready`. `tx_ready` falls the next cycle.
  - If a write and a byte-start load occur in the same cycle, the load takes the old content (or `IDLE_BYTE`), and the new byte is stored for the following byte.
- `miso_oe` = frame active. `miso` = `tx_shift[7]` when active, 0 otherwise.
- Reset mid-frame: after `rst` deasserts with `cs_n` low, the slave ignores `sclk` until `cs_n` is seen high, then resumes on the next falling edge.

## Timing
- Reset values:
  - `miso` 0, `miso_oe` 0, `rx_data` 8'h00, `rx_valid` 0
  - `tx_ready` 1, `tx_underrun` 0, `cnt` 0
  - holding register empty, sync flops 1 for `cs_n`, 0 for `sclk`/`mosi`
- Edge detect latency: 3 `clk` after a pin change.
- `miso` update: 4 `clk` after the `sclk` falling pin edge or the `cs_n` falling pin edge.
- `rx_valid`: 4 `clk` after the 8th `sclk` rising pin edge.
- Requirements on the master:
  - `sclk` high and low phases ≥ 6 `clk` periods each.
  - `cs_n` low ≥ 6 `clk` before the first `sclk` rising edge.
  - `cs_n` high ≥ 4 `clk` between frames.
- `mosi` must be stable from 1 `clk` before to 3 `clk` after the `sclk` rising pin edge.

## Test plan
- Single byte: `clk` 10 ns, master `PERIOD` 200 ns, holding register loaded with 8'hA5, master sends 8'h3C -> one `rx_valid` with `rx_data`=8'h3C; master reads 8'hA5; `tx_ready` returns to 1 at frame start.
- Underrun: no `tx_valid`, `IDLE_BYTE`=8'h00, master sends 8'hFF -> master reads 8'h00, one `tx_underrun` pulse, `rx_data`=8'hFF.
- Back-to-back frames, with `sclk` idling high between them: bytes 8'h81 then 8'h7E, tx 8'h55 then 8'hAA -> `rx_data` 8'h81 then 8'h7E; master reads 8'h55 then 8'hAA (no bit slip from the spurious falling edge).
- Abort: `cs_n` raised after 5 rising edges of 8'hC3 -> no `rx_valid`; the next full frame of 8'h12 yields `rx_data`=8'h12.
- Multi-byte frame: 3 bytes 8'h01, 8'h02, 8'h03 in one `cs_n` low period, tx refilled after each `tx_ready` -> three `rx_valid` pulses in order; `miso_oe` high throughout.
- Reset mid-frame: `rst` for 1 cycle after 3 bits -> all outputs at reset values; remaining edges ignored; the next frame sending 8'h9D is received correctly.
